// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
//   fetch_state_e : bus-side fetch state (IDLE / REQ / HALT)
//   TRAP_*        : trap codes carried by queue entries
//   fetch_entry_t : one prefetch queue record {instr, pc, is_trap, code}
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam logic [3:0] TRAP_INSTR_MISALIGNED   = 4'd0;
  localparam logic [3:0] TRAP_INSTR_ACCESS_FAULT = 4'd1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        is_trap;
    logic [3:0]  code;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  function automatic fetch_entry_t make_entry(input logic [31:0] instr,
                                              input logic [31:0] pc,
                                              input logic        is_trap,
                                              input logic [3:0]  code);
    fetch_entry_t e;
    e.instr   = instr;
    e.pc      = pc;
    e.is_trap = is_trap;
    e.code    = code;
    return e;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: DEPTH-entry circular FIFO with flush.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : drop all entries (rd_ptr := wr_ptr, count := 0); overrides push/pop
//   push_i       : write wdata_i at the tail (ignored when full and not popping)
//   wdata_i      : entry to write
//   pop_i        : advance the head (ignored when empty)
//   rdata_o      : head entry (raw storage, valid only while count_o != 0)
//   count_o      : number of stored entries, 0..DEPTH
module if_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 69
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are qualified by count_o.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a prefetch queue between Wishbone fetch and ID.
// Sequential fetches are issued while the queue has room; jump/branch and trap
// redirects flush the queue and discard any in-flight response.
// Optional build macro: IF_PREFETCH_BYPASS_EN -- an ack arriving while the
// queue is empty is presented to ID combinationally in the same cycle.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   redirect_valid_i, redirect_pc_i   : jump/branch taken and target (bit 0 ignored)
//   trap_valid_i, trap_pc_i           : trap taken and handler address (wins over redirect)
//   id_ready_i                        : ID consumes the head entry
//   id_valid_o, instr_o, PC_if_o,
//   PC4_if_o, is_trap_if_o,
//   trap_code_if_o                    : head entry towards ID
//   wbm_addr_if_o, wbm_cyc_if_o,
//   wbm_stb_if_o                      : Wishbone classic read request
//   wbm_dat_if_i, wbm_ack_if_i,
//   wbm_err_if_i                      : Wishbone read data and termination
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH      = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] PC_if_o,
  output logic [31:0] PC4_if_o,
  output logic        is_trap_if_o,
  output logic [3:0]  trap_code_if_o,
  output logic [31:0] wbm_addr_if_o,
  output logic        wbm_cyc_if_o,
  output logic        wbm_stb_if_o,
  input  logic [31:0] wbm_dat_if_i,
  input  logic        wbm_ack_if_i,
  input  logic        wbm_err_if_i
);

  localparam int unsigned CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  addr_q, addr_d;
  logic         discard_q, discard_d;

  logic                     push;
  fetch_entry_t             push_entry;
  logic [FETCH_ENTRY_W-1:0] head_raw;
  fetch_entry_t             head;
  logic [CW-1:0]            count;
  logic [CW-1:0]            count_after;
  logic                     head_valid;
  logic                     pop_fifo;
  logic                     redirect;
  logic [31:0]              target;
  logic                     term;
  logic                     bypass;
  logic                     unused_redirect_lsb;

  assign redirect   = trap_valid_i | redirect_valid_i;
  assign target     = trap_valid_i ? trap_pc_i : {redirect_pc_i[31:1], 1'b0};
  assign term       = (state_q == REQ) && (wbm_ack_if_i || wbm_err_if_i);
  assign head_valid = (count != '0);
  assign pop_fifo   = head_valid && id_ready_i;

`ifdef IF_PREFETCH_BYPASS_EN
  assign bypass = (state_q == REQ) && wbm_ack_if_i && !discard_q && !redirect && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    discard_d   = discard_q;
    push        = 1'b0;
    push_entry  = '0;
    count_after = count - CW'(pop_fifo);

    unique case (state_q)
      IDLE: begin
        if (count_after < FULL) begin
          if (fetch_pc_q[1:0] != 2'b00) begin
            push       = 1'b1;
            push_entry = make_entry('0, fetch_pc_q, 1'b1, TRAP_INSTR_MISALIGNED);
            state_d    = HALT;
          end else begin
            state_d = REQ;
            addr_d  = fetch_pc_q;
          end
        end
      end
      REQ: begin
        if (term) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (wbm_ack_if_i) begin
            // A bypassed entry consumed by ID in the same cycle is never stored.
            push       = !(bypass && id_ready_i);
            push_entry = make_entry(wbm_dat_if_i, fetch_pc_q, 1'b0, TRAP_INSTR_MISALIGNED);
            fetch_pc_d = fetch_pc_q + 32'd4;
          end else begin
            push       = 1'b1;
            push_entry = make_entry('0, fetch_pc_q, 1'b1, TRAP_INSTR_ACCESS_FAULT);
          end

          if (!discard_q && !wbm_ack_if_i) begin
            state_d = HALT;
          end else begin
            count_after = count_after + CW'(push);
            // A misaligned next address goes through IDLE, which raises the trap.
            if ((count_after < FULL) && (fetch_pc_d[1:0] == 2'b00)) begin
              state_d = REQ;
              addr_d  = fetch_pc_d;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (redirect) begin
      push       = 1'b0;
      fetch_pc_d = target;
      if ((state_q == REQ) && !term) begin
        // Keep the bus cycle (and its address) alive; drop its response later.
        discard_d = 1'b1;
        state_d   = REQ;
        addr_d    = addr_q;
      end else begin
        discard_d = 1'b0;
        if (target[1:0] == 2'b00) begin
          state_d = REQ;
          addr_d  = target;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_ADDR;
      addr_q     <= RESET_ADDR;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (redirect),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop_fifo),
    .rdata_o (head_raw),
    .count_o (count)
  );

  assign head = head_raw;

  // ID outputs read zero while no entry is presented.
  always_comb begin
    instr_o        = '0;
    PC_if_o        = '0;
    is_trap_if_o   = 1'b0;
    trap_code_if_o = '0;
    if (bypass) begin
      instr_o = wbm_dat_if_i;
      PC_if_o = fetch_pc_q;
    end else if (head_valid) begin
      instr_o        = head.instr;
      PC_if_o        = head.pc;
      is_trap_if_o   = head.is_trap;
      trap_code_if_o = head.code;
    end
  end

  assign id_valid_o    = head_valid | bypass;
  assign PC4_if_o      = PC_if_o + 32'd4;
  assign wbm_addr_if_o = addr_q;
  assign wbm_cyc_if_o  = (state_q == REQ);
  assign wbm_stb_if_o  = (state_q == REQ);

  assign unused_redirect_lsb = redirect_pc_i[0];

endmodule

// File: tb/tb_if_prefetch_stage.sv
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid, trap_valid, id_ready;
  logic [31:0] redirect_pc, trap_pc;
  logic        id_valid, is_trap;
  logic [31:0] instr, pc_if, pc4_if;
  logic [3:0]  trap_code;
  logic [31:0] wb_addr, wb_dat;
  logic        wb_cyc, wb_stb, wb_ack, wb_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_prefetch_stage #(
    .RESET_ADDR (32'h0000_0100),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .trap_valid_i     (trap_valid),
    .trap_pc_i        (trap_pc),
    .id_ready_i       (id_ready),
    .id_valid_o       (id_valid),
    .instr_o          (instr),
    .PC_if_o          (pc_if),
    .PC4_if_o         (pc4_if),
    .is_trap_if_o     (is_trap),
    .trap_code_if_o   (trap_code),
    .wbm_addr_if_o    (wb_addr),
    .wbm_cyc_if_o     (wb_cyc),
    .wbm_stb_if_o     (wb_stb),
    .wbm_dat_if_i     (wb_dat),
    .wbm_ack_if_i     (wb_ack),
    .wbm_err_if_i     (wb_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wb_ack = 0; wb_err = 0; wb_dat = '0;
    redirect_valid = 0; redirect_pc = '0;
    trap_valid = 0; trap_pc = '0;
    id_ready = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cyc"},   32'(wb_cyc), 32'd0);
    chk({tag, "_stb"},   32'(wb_stb), 32'd0);
    chk({tag, "_addr"},  wb_addr, 32'h100);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_pc"},    pc_if, 32'd0);
    chk({tag, "_pc4"},   pc4_if, 32'd4);
    chk({tag, "_trap"},  32'(is_trap), 32'd0);
    chk({tag, "_code"},  32'(trap_code), 32'd0);
  endtask

  typedef struct {
    logic        ack, err, rdy, rv, tv;
    logic [31:0] rpc, tpc;
    logic        e_cyc;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_pc, e_instr;
    logic        e_trap;
    logic [3:0]  e_code;
  } vec_t;

  function automatic vec_t v(input logic ack, err, rdy, rv, input logic [31:0] rpc,
                             input logic tv, input logic [31:0] tpc,
                             input logic e_cyc, input logic [31:0] e_addr,
                             input logic e_val, input logic [31:0] e_pc, e_instr,
                             input logic e_trap, input logic [3:0] e_code);
    vec_t r;
    r.ack = ack; r.err = err; r.rdy = rdy; r.rv = rv; r.rpc = rpc; r.tv = tv; r.tpc = tpc;
    r.e_cyc = e_cyc; r.e_addr = e_addr; r.e_val = e_val; r.e_pc = e_pc;
    r.e_instr = e_instr; r.e_trap = e_trap; r.e_code = e_code;
    return r;
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ment_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t        tbl [29];
    ment_t       mq[$];
    ment_t       me;
    logic [31:0] m_pc, tgt;
    logic        m_disc;
    int          stall;
    logic        cyc_s;

    // Cycle vectors: expectations hold at the start of the cycle, inputs are applied in it.
    // Bus read data in vector i is 0xA000_0000 + i.
    //             ack err rdy rv rpc            tv tpc            cyc addr          val pc            instr          trap code
    tbl[0]  = v(0, 0, 1, 0, 0,            0, 0,            0, 0,            0, 0,            0,            0, 0);
    tbl[1]  = v(1, 0, 1, 0, 0,            0, 0,            1, 32'h100,      0, 0,            0,            0, 0);
    tbl[2]  = v(1, 0, 1, 0, 0,            0, 0,            1, 32'h104,      1, 32'h100,      32'hA000_0001, 0, 0);
    tbl[3]  = v(1, 0, 1, 0, 0,            0, 0,            1, 32'h108,      1, 32'h104,      32'hA000_0002, 0, 0);
    tbl[4]  = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h10C,      1, 32'h108,      32'hA000_0003, 0, 0);
    tbl[5]  = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h110,      1, 32'h108,      32'hA000_0003, 0, 0);
    tbl[6]  = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h114,      1, 32'h108,      32'hA000_0003, 0, 0);
    tbl[7]  = v(0, 0, 0, 0, 0,            0, 0,            0, 0,            1, 32'h108,      32'hA000_0003, 0, 0);
    tbl[8]  = v(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, 32'h108,      32'hA000_0003, 0, 0);
    tbl[9]  = v(0, 0, 0, 1, 32'h200,      0, 0,            1, 32'h118,      1, 32'h10C,      32'hA000_0004, 0, 0);
    tbl[10] = v(0, 0, 1, 0, 0,            0, 0,            1, 32'h118,      0, 0,            0,            0, 0);
    tbl[11] = v(0, 0, 1, 0, 0,            0, 0,            1, 32'h118,      0, 0,            0,            0, 0);
    tbl[12] = v(1, 0, 1, 0, 0,            0, 0,            1, 32'h118,      0, 0,            0,            0, 0);
    tbl[13] = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h200,      0, 0,            0,            0, 0);
    tbl[14] = v(1, 0, 0, 1, 32'h300,      1, 32'h80,       1, 32'h204,      1, 32'h200,      32'hA000_000D, 0, 0);
    tbl[15] = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h080,      0, 0,            0,            0, 0);
    tbl[16] = v(0, 0, 0, 1, 32'h303,      0, 0,            1, 32'h084,      1, 32'h080,      32'hA000_000F, 0, 0);
    tbl[17] = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h084,      0, 0,            0,            0, 0);
    tbl[18] = v(0, 0, 0, 0, 0,            0, 0,            0, 0,            0, 0,            0,            0, 0);
    tbl[19] = v(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, 32'h302,      0,            1, 4'd0);
    tbl[20] = v(0, 0, 0, 0, 0,            0, 0,            0, 0,            0, 0,            0,            0, 0);
    tbl[21] = v(0, 0, 0, 1, 32'h40,       0, 0,            0, 0,            0, 0,            0,            0, 0);
    tbl[22] = v(0, 1, 0, 0, 0,            0, 0,            1, 32'h040,      0, 0,            0,            0, 0);
    tbl[23] = v(0, 0, 0, 0, 0,            0, 0,            0, 0,            1, 32'h040,      0,            1, 4'd1);
    tbl[24] = v(0, 0, 1, 0, 0,            0, 0,            0, 0,            1, 32'h040,      0,            1, 4'd1);
    tbl[25] = v(0, 0, 0, 0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0, 0,            0,            0, 0);
    tbl[26] = v(1, 0, 0, 0, 0,            0, 0,            1, 32'hFFFF_FFFC, 0, 0,            0,            0, 0);
    tbl[27] = v(0, 0, 1, 0, 0,            0, 0,            1, 32'h0,        1, 32'hFFFF_FFFC, 32'hA000_001A, 0, 0);
    tbl[28] = v(1, 0, 0, 0, 0,            0, 0,            1, 32'h0,        0, 0,            0,            0, 0);

    drive_idle();
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

`ifdef IF_PREFETCH_BYPASS_EN
    // Empty queue: an ack is visible to ID in the same cycle.
    @(negedge clk);
    chk("byp_cyc", 32'(wb_cyc), 32'd1);
    wb_ack = 1; wb_dat = 32'hCAFE_0001;
    #1;
    chk("byp_valid_same_cycle", 32'(id_valid), 32'd1);
    chk("byp_instr", instr, 32'hCAFE_0001);
    chk("byp_pc", pc_if, 32'h100);
    @(negedge clk);
    wb_ack = 0;
    #1;
    chk("byp_pushed_valid", 32'(id_valid), 32'd1);
    chk("byp_pushed_pc", pc_if, 32'h100);
    chk("byp_next_addr", wb_addr, 32'h104);
`else
    for (int i = 0; i < 29; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("v%0d_cyc", i), 32'(wb_cyc), 32'(tbl[i].e_cyc));
      chk($sformatf("v%0d_stb", i), 32'(wb_stb), 32'(tbl[i].e_cyc));
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(tbl[i].e_val));
      if (tbl[i].e_cyc) chk($sformatf("v%0d_addr", i), wb_addr, tbl[i].e_addr);
      if (tbl[i].e_val) begin
        chk($sformatf("v%0d_pc", i), pc_if, tbl[i].e_pc);
        chk($sformatf("v%0d_pc4", i), pc4_if, tbl[i].e_pc + 32'd4);
        chk($sformatf("v%0d_instr", i), instr, tbl[i].e_instr);
        chk($sformatf("v%0d_trap", i), 32'(is_trap), 32'(tbl[i].e_trap));
        chk($sformatf("v%0d_code", i), 32'(trap_code), 32'(tbl[i].e_code));
      end
      wb_ack = tbl[i].ack; wb_err = tbl[i].err; id_ready = tbl[i].rdy;
      wb_dat = 32'hA000_0000 + 32'(i);
      redirect_valid = tbl[i].rv; redirect_pc = tbl[i].rpc;
      trap_valid = tbl[i].tv; trap_pc = tbl[i].tpc;
    end

    // Entry fetched from address 0 after the wrap, then reset in the middle of a bus cycle.
    @(negedge clk);
    chk("wrap_valid", 32'(id_valid), 32'd1);
    chk("wrap_pc", pc_if, 32'h0);
    chk("wrap_pc4", pc4_if, 32'h4);
    chk("wrap_instr", instr, 32'hA000_001C);
    chk("wrap_cyc_active", 32'(wb_cyc), 32'd1);
    drive_idle();
    rst = 1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 0;

    // Randomized traffic against a transaction-level model of the queue contents.
    mq.delete();
    m_pc   = 32'h100;
    m_disc = 1'b0;
    stall  = 0;
    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge clk);
      cyc_s = wb_cyc;
      chk("rnd_valid", 32'(id_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("rnd_pc", pc_if, mq[0].pc);
        chk("rnd_pc4", pc4_if, mq[0].pc + 32'd4);
        chk("rnd_instr", instr, mq[0].instr);
        chk("rnd_trap", 32'(is_trap), 32'd0);
      end
      if (!cyc_s && (mq.size() < DEPTH)) stall++;
      else stall = 0;
      chk("rnd_req_stall", 32'(stall <= 2), 32'd1);
      if (cyc_s && !m_disc) begin
        chk("rnd_addr", wb_addr, m_pc);
        chk("rnd_space", 32'(mq.size() < DEPTH), 32'd1);
      end

      wb_ack   = cyc_s && ($urandom_range(0, 99) < 60);
      wb_err   = 1'b0;
      wb_dat   = $urandom();
      id_ready = 1'($urandom_range(0, 1));
      begin
        int r;
        r = $urandom_range(0, 99);
        tgt = $urandom() & 32'hFFFF_FFFC;
        redirect_valid = (r < 4) || (r == 99);
        trap_valid     = (r >= 97);
        redirect_pc    = tgt | 32'($urandom_range(0, 1));
        tgt = $urandom() & 32'hFFFF_FFFC;
        trap_pc        = tgt;
      end

      if (redirect_valid || trap_valid) begin
        mq.delete();
        m_pc   = trap_valid ? trap_pc : (redirect_pc & 32'hFFFF_FFFE);
        m_disc = cyc_s && !wb_ack;
      end else begin
        if ((mq.size() != 0) && id_ready) void'(mq.pop_front());
        if (cyc_s && wb_ack) begin
          if (m_disc) begin
            m_disc = 1'b0;
          end else begin
            me.instr = wb_dat;
            me.pc    = m_pc;
            mq.push_back(me);
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
`endif

    @(negedge clk);
    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
